// File: rtl/bus_dev_pkg.sv
// Shared constants and helpers for the bus device port.
// Holds the destination-field width, the default broadcast ID and the field extractor.
// No logic state; pure declarations.
package bus_dev_pkg;

    localparam int DEST_W = 8;
    localparam logic [DEST_W-1:0] BROADCAST_ID_DEF = 8'b1000_1111;

    // Widest packet the extractor accepts; callers zero-extend into this width.
    localparam int PKT_MAX_W = 256;

    // Destination is the top DEST_W bits of a pkt_w-wide packet.
    function automatic logic [DEST_W-1:0] get_dest(input logic [PKT_MAX_W-1:0] pkt,
                                                   input int pkt_w);
        return DEST_W'(pkt >> (pkt_w - DEST_W));
    endfunction

endpackage

// File: rtl/bus_dev_fifo.sv
// Show-ahead synchronous FIFO: head entry is always visible on o_rd_data.
// Latency: a write is visible (o_empty low) the cycle after it is accepted.
// Backpressure: writes while full and reads while empty are ignored; a same-cycle read never frees room for a write.
module bus_dev_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_wr_en,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd_en,
    output logic [W-1:0] o_rd_data,
    output logic         o_empty,
    output logic         o_full
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [W-1:0]     r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CNT_W-1:0] r_cnt;

    logic w_wr;
    logic w_rd;

    // Full/empty come straight from the registered count so they never depend on inputs.
    assign o_full    = (r_cnt == FULL_CNT);
    assign o_empty   = (r_cnt == '0);
    assign w_wr      = i_wr_en & ~o_full;
    assign w_rd      = i_rd_en & ~o_empty;
    assign o_rd_data = r_mem[r_rptr];

    // Storage is deliberately not reset; stale contents are hidden by the count.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_rd})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/bus_dev_port.sv
// Bus device port: TX FIFO towards the bus, RX FIFO from the bus, saturating drop counter.
// Latency: one cycle from accepted write/push to pndng/rx_vld; show-ahead heads on D_pop/rx_data.
// Backpressure: tx_wr ignored while tx_full; pushes dropped (and counted) while RX full or filtered.
// Optional destination filtering is enabled with the macro BUS_DEV_ADDR_FILTER_EN.
module bus_dev_port
    import bus_dev_pkg::*;
#(
    parameter int               pckg_sz   = 32,
    parameter int               depth     = 16,
    parameter logic [DEST_W-1:0] id        = 8'h00,
    parameter logic [DEST_W-1:0] broadcast = BROADCAST_ID_DEF
) (
    input  logic               clk,
    input  logic               reset,
    output logic               pndng,
    output logic [pckg_sz-1:0] D_pop,
    input  logic               pop,
    input  logic               push,
    input  logic [pckg_sz-1:0] D_push,
    input  logic               tx_wr,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    input  logic               rx_rd,
    output logic [pckg_sz-1:0] rx_data,
    output logic               rx_vld,
    output logic [7:0]         rx_drop_cnt
);
`ifdef BUS_DEV_ADDR_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    logic              w_tx_empty;
    logic              w_rx_empty;
    logic              w_rx_full;
    logic [DEST_W-1:0] w_dest;
    logic              w_addr_hit;
    logic              w_accept;
    logic              w_drop;
    logic [7:0]        r_drop_cnt;

    assign w_dest     = get_dest(PKT_MAX_W'(D_push), pckg_sz);
    assign w_addr_hit = (w_dest == id) || (w_dest == broadcast);
    assign w_accept   = FILTER_EN ? w_addr_hit : 1'b1;
    assign w_drop     = push & (~w_accept | w_rx_full);

    assign pndng       = ~w_tx_empty;
    assign rx_vld      = ~w_rx_empty;
    assign rx_drop_cnt = r_drop_cnt;

    bus_dev_fifo #(
        .W     (pckg_sz),
        .DEPTH (depth)
    ) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (tx_wr),
        .i_wr_data (tx_data),
        .i_rd_en   (pop),
        .o_rd_data (D_pop),
        .o_empty   (w_tx_empty),
        .o_full    (tx_full)
    );

    bus_dev_fifo #(
        .W     (pckg_sz),
        .DEPTH (depth)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (push & w_accept),
        .i_wr_data (D_push),
        .i_rd_en   (rx_rd),
        .o_rd_data (rx_data),
        .o_empty   (w_rx_empty),
        .o_full    (w_rx_full)
    );

    // Count every dropped push (RX full or filtered out), holding at 8'hFF.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
            r_drop_cnt <= r_drop_cnt + 8'd1;
        end
    end

endmodule
